// File: rtl/sprite_anim_engine.sv
// sprite_anim_engine: table-driven sprite animation sequencer and sprite ROM
// address generator. Holds NUM_ANIMS programmable descriptors, steps the
// selected animation on rising edges of frame_clk, and maps the current VGA
// pixel to a sprite ROM address with optional horizontal mirroring.
//
// Ports
//   Clk, Reset            system clock, synchronous active-low reset
//   frame_clk             vertical-rate strobe, rising edge detected on Clk
//   anim_sel/anim_restart animation select / restart pulse
//   mirror                draw horizontally flipped
//   cfg_*                 descriptor write port (cfg_we strobe, cfg_anim index)
//   DrawX/DrawY           current VGA pixel
//   PlayerX/PlayerY       sprite top-left screen position
//   spriteAddress/spriteOn ROM read address and in-box flag (2-cycle latency)
//   PlayerWidth/Height    dimensions of the active animation
//   frame_idx, anim_done  current frame, one-shot parked on last frame
module sprite_anim_engine #(
   parameter int unsigned NUM_ANIMS = 8,
   parameter int unsigned FRAME_W   = 3,
   parameter int unsigned HOLD_W    = 4,
   parameter int unsigned ADDR_W    = 21,
   parameter int unsigned COORD_W   = 10,
   localparam int unsigned ANIM_W   = $clog2(NUM_ANIMS)
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               frame_clk,
   input  logic [ANIM_W-1:0]  anim_sel,
   input  logic               anim_restart,
   input  logic               mirror,
   input  logic               cfg_we,
   input  logic [ANIM_W-1:0]  cfg_anim,
   input  logic [ADDR_W-1:0]  cfg_base,
   input  logic [COORD_W-1:0] cfg_width,
   input  logic [COORD_W-1:0] cfg_height,
   input  logic [FRAME_W-1:0] cfg_frames,
   input  logic [HOLD_W-1:0]  cfg_hold,
   input  logic               cfg_loop,
   input  logic [COORD_W-1:0] DrawX,
   input  logic [COORD_W-1:0] DrawY,
   input  logic [COORD_W-1:0] PlayerX,
   input  logic [COORD_W-1:0] PlayerY,
   output logic [ADDR_W-1:0]  spriteAddress,
   output logic               spriteOn,
   output logic [COORD_W-1:0] PlayerWidth,
   output logic [COORD_W-1:0] PlayerHeight,
   output logic [FRAME_W-1:0] frame_idx,
   output logic               anim_done
);

   localparam int unsigned PROD_W = 2 * COORD_W;
   localparam int unsigned FCMP_W = FRAME_W + 1;
   localparam int unsigned XCMP_W = COORD_W + 1;

   typedef struct packed {
      logic [ADDR_W-1:0]  base;
      logic [COORD_W-1:0] width;
      logic [COORD_W-1:0] height;
      logic [FRAME_W-1:0] frames;
      logic [HOLD_W-1:0]  hold;
      logic               loop;
   } desc_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      DONE = 2'd2
   } state_t;

   desc_t               desc_mem [NUM_ANIMS];
   desc_t               shadow;
   state_t              state;
   logic [ANIM_W-1:0]   active;
   logic [HOLD_W-1:0]   hold_cnt;
   logic [ADDR_W-1:0]   frame_base;
   logic                frame_clk_q;

   logic                tick_c;
   logic                start_c;
   logic                last_frame_c;
   desc_t               sel_desc_c;
   desc_t               cfg_desc_c;
   logic [PROD_W-1:0]   frame_size_c;

   assign tick_c       = frame_clk & ~frame_clk_q;
   assign start_c      = (anim_sel != active) | anim_restart;
   assign sel_desc_c   = desc_mem[anim_sel];
   assign cfg_desc_c   = '{base: cfg_base, width: cfg_width, height: cfg_height,
                           frames: cfg_frames, hold: cfg_hold, loop: cfg_loop};
   assign frame_size_c = {{COORD_W{1'b0}}, shadow.width} * {{COORD_W{1'b0}}, shadow.height};
   // Compare one bit wider so frames-1 never underflows.
   assign last_frame_c = !((FCMP_W'(frame_idx) + FCMP_W'(1)) < FCMP_W'(shadow.frames));

   // Descriptor table; reads for Start see the pre-write contents.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         for (int i = 0; i < NUM_ANIMS; i++) desc_mem[i] <= '0;
      end else if (cfg_we) begin
         desc_mem[cfg_anim] <= cfg_desc_c;
      end
   end

   // Sequencer: Start wins over tick; the active animation runs from a shadow copy.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state        <= IDLE;
         active       <= '0;
         shadow       <= '0;
         frame_idx    <= '0;
         hold_cnt     <= '0;
         frame_base   <= '0;
         anim_done    <= 1'b0;
         PlayerWidth  <= '0;
         PlayerHeight <= '0;
         frame_clk_q  <= 1'b0;
      end else begin
         frame_clk_q <= frame_clk;
         if (start_c) begin
            active     <= anim_sel;
            shadow     <= sel_desc_c;
            frame_idx  <= '0;
            hold_cnt   <= '0;
            frame_base <= sel_desc_c.base;
            anim_done  <= 1'b0;
            if (sel_desc_c.frames == '0) begin
               state        <= IDLE;
               PlayerWidth  <= '0;
               PlayerHeight <= '0;
            end else begin
               state        <= PLAY;
               PlayerWidth  <= sel_desc_c.width;
               PlayerHeight <= sel_desc_c.height;
            end
         end else if (tick_c && (state == PLAY)) begin
            if (hold_cnt < shadow.hold) begin
               hold_cnt <= hold_cnt + HOLD_W'(1);
            end else begin
               hold_cnt <= '0;
               if (!last_frame_c) begin
                  frame_idx  <= frame_idx + FRAME_W'(1);
                  frame_base <= frame_base + ADDR_W'(frame_size_c);
               end else if (shadow.loop) begin
                  frame_idx  <= '0;
                  frame_base <= shadow.base;
               end else begin
                  state     <= DONE;
                  anim_done <= 1'b1;
               end
            end
         end
      end
   end

   // Pixel pipeline stage 1: box test with one extra bit so boxes near the
   // right/bottom screen edge do not wrap back to column/row 0.
   logic [XCMP_W-1:0]  x_end_c;
   logic [XCMP_W-1:0]  y_end_c;
   logic               in_c;
   logic [COORD_W-1:0] dx_c;
   logic [COORD_W-1:0] dy_c;
   logic [COORD_W-1:0] col_c;
   logic               in_q;
   logic [COORD_W-1:0] dy_q;
   logic [COORD_W-1:0] col_q;

   assign x_end_c = XCMP_W'(PlayerX) + XCMP_W'(shadow.width);
   assign y_end_c = XCMP_W'(PlayerY) + XCMP_W'(shadow.height);
   assign in_c    = (DrawX >= PlayerX) && (XCMP_W'(DrawX) < x_end_c) &&
                    (DrawY >= PlayerY) && (XCMP_W'(DrawY) < y_end_c);
   assign dx_c    = DrawX - PlayerX;
   assign dy_c    = DrawY - PlayerY;
   assign col_c   = mirror ? (shadow.width - COORD_W'(1) - dx_c) : dx_c;

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         in_q  <= 1'b0;
         dy_q  <= '0;
         col_q <= '0;
      end else begin
         in_q  <= in_c;
         dy_q  <= dy_c;
         col_q <= col_c;
      end
   end

   // Pixel pipeline stage 2: row-major address within the current frame.
   logic [PROD_W-1:0] row_off_c;
   logic [ADDR_W-1:0] addr_c;
   logic              on_c;

   assign row_off_c = {{COORD_W{1'b0}}, dy_q} * {{COORD_W{1'b0}}, shadow.width};
   assign addr_c    = frame_base + ADDR_W'(row_off_c) + ADDR_W'(col_q);
   assign on_c      = in_q && (state != IDLE);

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         spriteOn      <= 1'b0;
         spriteAddress <= '0;
      end else begin
         spriteOn      <= on_c;
         spriteAddress <= on_c ? addr_c : '0;
      end
   end

endmodule

// File: tb/tb_sprite_anim_engine.sv
// tb_sprite_anim_engine: directed and randomized checks of sprite_anim_engine
// against a frame-count reference model (frame = elapsed ticks / (hold+1)).
module tb_sprite_anim_engine;

   localparam int unsigned NUM_ANIMS = 8;
   localparam int unsigned FRAME_W   = 3;
   localparam int unsigned HOLD_W    = 4;
   localparam int unsigned ADDR_W    = 21;
   localparam int unsigned COORD_W   = 10;
   localparam int unsigned ANIM_W    = 3;
   localparam longint      ADDR_MASK = (64'd1 << ADDR_W) - 1;

   logic               Clk = 1'b0;
   logic               Reset = 1'b0;
   logic               frame_clk = 1'b0;
   logic [ANIM_W-1:0]  anim_sel = '0;
   logic               anim_restart = 1'b0;
   logic               mirror = 1'b0;
   logic               cfg_we = 1'b0;
   logic [ANIM_W-1:0]  cfg_anim = '0;
   logic [ADDR_W-1:0]  cfg_base = '0;
   logic [COORD_W-1:0] cfg_width = '0;
   logic [COORD_W-1:0] cfg_height = '0;
   logic [FRAME_W-1:0] cfg_frames = '0;
   logic [HOLD_W-1:0]  cfg_hold = '0;
   logic               cfg_loop = 1'b0;
   logic [COORD_W-1:0] DrawX = '0;
   logic [COORD_W-1:0] DrawY = '0;
   logic [COORD_W-1:0] PlayerX = '0;
   logic [COORD_W-1:0] PlayerY = '0;
   logic [ADDR_W-1:0]  spriteAddress;
   logic               spriteOn;
   logic [COORD_W-1:0] PlayerWidth;
   logic [COORD_W-1:0] PlayerHeight;
   logic [FRAME_W-1:0] frame_idx;
   logic               anim_done;

   sprite_anim_engine dut (
      .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .anim_sel(anim_sel),
      .anim_restart(anim_restart), .mirror(mirror), .cfg_we(cfg_we), .cfg_anim(cfg_anim),
      .cfg_base(cfg_base), .cfg_width(cfg_width), .cfg_height(cfg_height),
      .cfg_frames(cfg_frames), .cfg_hold(cfg_hold), .cfg_loop(cfg_loop),
      .DrawX(DrawX), .DrawY(DrawY), .PlayerX(PlayerX), .PlayerY(PlayerY),
      .spriteAddress(spriteAddress), .spriteOn(spriteOn), .PlayerWidth(PlayerWidth),
      .PlayerHeight(PlayerHeight), .frame_idx(frame_idx), .anim_done(anim_done)
   );

   always #5 Clk = ~Clk;

   int total = 0;
   int bad   = 0;

   // Reference model: descriptor table, shadow copy and elapsed tick count.
   int d_base [NUM_ANIMS];
   int d_w    [NUM_ANIMS];
   int d_h    [NUM_ANIMS];
   int d_fr   [NUM_ANIMS];
   int d_hold [NUM_ANIMS];
   bit d_loop [NUM_ANIMS];
   int s_base, s_w, s_h, s_fr, s_hold;
   bit s_loop;
   int m_active;
   bit m_run, m_done, m_prev_fc;
   int m_ticks;

   function automatic int exp_frame();
      int q;
      if (!m_run) return 0;
      if (m_done) return s_fr - 1;
      q = m_ticks / (s_hold + 1);
      return s_loop ? (q % s_fr) : q;
   endfunction

   function automatic longint exp_fb();
      return (longint'(s_base) + longint'(exp_frame()) * s_w * s_h) & ADDR_MASK;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Advance the model by one Clk edge using the currently driven inputs.
   task automatic model_edge();
      bit tick;
      if (!Reset) begin
         for (int i = 0; i < NUM_ANIMS; i++) begin
            d_base[i] = 0; d_w[i] = 0; d_h[i] = 0; d_fr[i] = 0; d_hold[i] = 0; d_loop[i] = 0;
         end
         s_base = 0; s_w = 0; s_h = 0; s_fr = 0; s_hold = 0; s_loop = 0;
         m_active = 0; m_run = 0; m_done = 0; m_ticks = 0; m_prev_fc = 0;
         return;
      end
      tick = frame_clk && !m_prev_fc;
      m_prev_fc = frame_clk;
      if (int'(anim_sel) != m_active || anim_restart) begin
         m_active = int'(anim_sel);
         s_base = d_base[m_active]; s_w = d_w[m_active]; s_h = d_h[m_active];
         s_fr = d_fr[m_active]; s_hold = d_hold[m_active]; s_loop = d_loop[m_active];
         m_run = (s_fr != 0); m_done = 0; m_ticks = 0;
      end else if (tick && m_run && !m_done) begin
         m_ticks++;
         if (!s_loop && (m_ticks / (s_hold + 1)) >= s_fr) m_done = 1;
      end
      if (cfg_we) begin
         d_base[cfg_anim] = int'(cfg_base); d_w[cfg_anim] = int'(cfg_width);
         d_h[cfg_anim] = int'(cfg_height); d_fr[cfg_anim] = int'(cfg_frames);
         d_hold[cfg_anim] = int'(cfg_hold); d_loop[cfg_anim] = cfg_loop;
      end
   endtask

   task automatic step();
      model_edge();
      @(posedge Clk);
      #1;
      chk("frame_idx", 64'(frame_idx), 64'(exp_frame()));
      chk("anim_done", 64'(anim_done), 64'(m_done));
      chk("PlayerWidth", 64'(PlayerWidth), 64'(m_run ? s_w : 0));
      chk("PlayerHeight", 64'(PlayerHeight), 64'(m_run ? s_h : 0));
   endtask

   task automatic do_tick();
      frame_clk = 1'b1; step();
      frame_clk = 1'b0; step();
   endtask

   task automatic set_cfg(input int idx, input int base, input int w, input int h,
                          input int fr, input int hold, input bit lp);
      cfg_anim = ANIM_W'(idx); cfg_base = ADDR_W'(base); cfg_width = COORD_W'(w);
      cfg_height = COORD_W'(h); cfg_frames = FRAME_W'(fr); cfg_hold = HOLD_W'(hold);
      cfg_loop = lp;
   endtask

   task automatic cfg_write(input int idx, input int base, input int w, input int h,
                            input int fr, input int hold, input bit lp);
      set_cfg(idx, base, w, h, fr, hold, lp);
      cfg_we = 1'b1; step(); cfg_we = 1'b0;
   endtask

   task automatic restart();
      anim_restart = 1'b1; step(); anim_restart = 1'b0;
   endtask

   // Drive one pixel, wait out the 2-cycle pipeline, compare against the model.
   task automatic pix(input int x, input int y, input int px, input int py, input bit mir);
      bit  on;
      int  col;
      longint addr;
      DrawX = COORD_W'(x); DrawY = COORD_W'(y); PlayerX = COORD_W'(px); PlayerY = COORD_W'(py);
      mirror = mir;
      on = m_run && x >= px && x < px + s_w && y >= py && y < py + s_h;
      col = mir ? (s_w - 1 - (x - px)) : (x - px);
      addr = on ? ((exp_fb() + longint'(y - py) * s_w + col) & ADDR_MASK) : 0;
      step(); step();
      chk("spriteOn", 64'(spriteOn), 64'(on));
      chk("spriteAddress", 64'(spriteAddress), 64'(addr));
   endtask

   initial begin
      int seq [8];
      seq = '{0, 0, 1, 1, 2, 2, 0, 0};

      // Power-on reset.
      Reset = 1'b0; step(); step();
      chk("rst_spriteOn", 64'(spriteOn), 64'd0);
      chk("rst_addr", 64'(spriteAddress), 64'd0);
      chk("rst_frame", 64'(frame_idx), 64'd0);
      chk("rst_width", 64'(PlayerWidth), 64'd0);
      Reset = 1'b1; step();

      // Looping anim 2: frame sequence across 8 ticks.
      cfg_write(2, 'h100, 16, 32, 3, 1, 1'b1);
      cfg_write(5, 'h4000, 20, 10, 2, 0, 1'b1);
      anim_sel = 3'd2; step();
      chk("sel_width", 64'(PlayerWidth), 64'd16);
      chk("sel_height", 64'(PlayerHeight), 64'd32);
      for (int i = 0; i < 8; i++) begin
         chk("loop_seq", 64'(frame_idx), 64'(seq[i]));
         do_tick();
      end
      restart();

      // Address pipeline on frames 0, 1, 2.
      pix(100, 50, 100, 50, 1'b0);
      chk("addr_f0", 64'(spriteAddress), 64'h100);
      pix(100, 50, 100, 50, 1'b1);
      chk("addr_mirror", 64'(spriteAddress), 64'h10F);
      pix(105, 52, 100, 50, 1'b0);
      chk("addr_inner", 64'(spriteAddress), 64'h100 + 2 * 16 + 5);
      pix(116, 50, 100, 50, 1'b0);
      chk("right_edge_off", 64'(spriteOn), 64'd0);
      pix(3, 50, 1020, 50, 1'b0);
      chk("no_wrap_off", 64'(spriteOn), 64'd0);
      do_tick(); do_tick();
      pix(100, 50, 100, 50, 1'b0);
      chk("addr_f1", 64'(spriteAddress), 64'h300);
      do_tick(); do_tick();
      pix(100, 50, 100, 50, 1'b0);
      chk("addr_f2", 64'(spriteAddress), 64'h500);

      // One-shot: parks on frame 2 after the 6th tick.
      cfg_write(2, 'h100, 16, 32, 3, 1, 1'b0);
      restart();
      for (int i = 0; i < 5; i++) do_tick();
      chk("oneshot_not_done", 64'(anim_done), 64'd0);
      do_tick();
      chk("oneshot_done", 64'(anim_done), 64'd1);
      chk("oneshot_frame", 64'(frame_idx), 64'd2);
      do_tick(); do_tick();
      chk("done_hold_frame", 64'(frame_idx), 64'd2);
      chk("done_hold_flag", 64'(anim_done), 64'd1);
      restart();
      chk("restart_frame", 64'(frame_idx), 64'd0);
      chk("restart_done", 64'(anim_done), 64'd0);

      // Descriptor rewrite of the active anim waits for the next Start.
      cfg_write(2, 'h100, 8, 32, 3, 1, 1'b0);
      chk("shadow_width", 64'(PlayerWidth), 64'd16);
      restart();
      chk("new_width", 64'(PlayerWidth), 64'd8);

      // Select change coincident with a tick discards the tick.
      do_tick();
      cfg_write(3, 'h2000, 8, 8, 4, 0, 1'b1);
      frame_clk = 1'b1; anim_sel = 3'd3; step();
      chk("start_tick_frame", 64'(frame_idx), 64'd0);
      frame_clk = 1'b0; step();
      do_tick();
      chk("after_start_tick", 64'(frame_idx), 64'd1);

      // Start and write on the same index: shadow takes the old contents.
      set_cfg(5, 'h4000, 40, 10, 2, 0, 1'b1);
      cfg_we = 1'b1; anim_sel = 3'd5; step(); cfg_we = 1'b0;
      chk("same_cycle_old", 64'(PlayerWidth), 64'd20);
      restart();
      chk("same_cycle_new", 64'(PlayerWidth), 64'd40);

      // Reset pulse mid-PLAY clears the sequencer and the descriptor table.
      do_tick();
      Reset = 1'b0; step(); Reset = 1'b1;
      chk("midrst_frame", 64'(frame_idx), 64'd0);
      chk("midrst_on", 64'(spriteOn), 64'd0);
      chk("midrst_done", 64'(anim_done), 64'd0);
      step();
      chk("cleared_desc_width", 64'(PlayerWidth), 64'd0);
      pix(10, 10, 10, 10, 1'b0);
      chk("cleared_desc_on", 64'(spriteOn), 64'd0);

      // Randomized traffic against the model.
      for (int it = 0; it < 400; it++) begin
         int op;
         op = int'($urandom_range(0, 9));
         if (op == 0) begin
            int w, h, idx;
            idx = int'($urandom_range(0, NUM_ANIMS - 1));
            w = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 48)) : int'($urandom_range(1, 1023));
            h = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 48)) : int'($urandom_range(1, 1023));
            set_cfg(idx, int'($urandom & 32'(ADDR_MASK)), w, h, int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) anim_sel = ANIM_W'(idx);
            cfg_we = 1'b1; step(); cfg_we = 1'b0;
         end else if (op == 1) begin
            anim_sel = ANIM_W'($urandom_range(0, NUM_ANIMS - 1)); step();
         end else if (op == 2) begin
            restart();
         end else if (op <= 6) begin
            do_tick();
         end else begin
            int px, py, x, y;
            px = int'($urandom_range(0, 1023));
            py = int'($urandom_range(0, 1023));
            x = (px + int'($urandom_range(0, s_w + 4)) - 2 + 1024) % 1024;
            y = (py + int'($urandom_range(0, s_h + 4)) - 2 + 1024) % 1024;
            pix(x, y, px, py, 1'($urandom_range(0, 1)));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
